// File: rtl/bru_redirect_unit.sv
// bru_redirect_unit: branch resolution and frontend redirect.
// Takes the decoder's resolved branch and the frontend prediction, computes the
// architectural next PC, pulses a completion to the ROB one cycle after accept,
// and on a mispredict holds a redirect request (with a one-cycle backend flush)
// until the frontend accepts it or an ROB flush cancels it.
// Optional feature macro: BRU_PERF_CNT_EN (saturating branch / mispredict counters).
module bru_redirect_unit #(
    parameter int ROB_IDX_W = 6
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic [ROB_IDX_W-1:0] rob_idx_in,
    input  logic [63:0]          pc_in,
    input  logic                 taken_in,
    input  logic [18:0]          offset_in,
    input  logic                 is_bl_in,
    input  logic                 pred_taken_in,
    input  logic [63:0]          pred_target_in,
    input  logic                 rob_flush_in,
    output logic                 complete_valid_out,
    output logic [ROB_IDX_W-1:0] complete_rob_idx_out,
    output logic                 mispredict_out,
    output logic                 redirect_valid_out,
    output logic [63:0]          redirect_pc_out,
    input  logic                 redirect_ready_in,
    output logic                 flush_out,
    output logic [31:0]          perf_branches_out,
    output logic [31:0]          perf_mispred_out
);

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic                   complete_valid_q, complete_valid_d;
    logic [ROB_IDX_W-1:0]   complete_rob_idx_q, complete_rob_idx_d;
    logic                   mispredict_q, mispredict_d;
    logic                   flush_q, flush_d;
    logic [63:0]            redirect_pc_q, redirect_pc_d;

    logic                   accept;
    logic                   resolve;
    logic                   mispred;
    logic [63:0]            actual_next;
    logic [63:0]            pred_next;

    // The decoder already folds direction into the offset (not-taken arrives
    // as +4), so taken_in and is_bl_in carry no extra information here.
    logic unused_inputs;
    assign unused_inputs = taken_in ^ is_bl_in;

    // Next-PC comparison: direction-only and target-only mismatches both show
    // up as a differing next PC.
    always_comb begin
        actual_next = pc_in + {{45{offset_in[18]}}, offset_in};
        pred_next   = pred_taken_in ? pred_target_in : (pc_in + 64'd4);
        mispred     = (actual_next != pred_next);
    end

    assign ready_out          = (state_q == IDLE);
    assign accept             = valid_in && ready_out;
    // An ROB flush in the accept cycle discards the branch entirely.
    assign resolve            = accept && !rob_flush_in;

    assign complete_valid_out   = complete_valid_q;
    assign complete_rob_idx_out = complete_rob_idx_q;
    assign mispredict_out       = mispredict_q;
    assign flush_out            = flush_q;
    assign redirect_valid_out   = (state_q == REDIRECT);
    assign redirect_pc_out      = redirect_pc_q;

    // Next-state and registered-output computation.
    always_comb begin
        state_d            = state_q;
        complete_valid_d   = resolve;
        complete_rob_idx_d = accept ? rob_idx_in : complete_rob_idx_q;
        mispredict_d       = resolve && mispred;
        flush_d            = resolve && mispred;
        redirect_pc_d      = redirect_pc_q;
        case (state_q)
            IDLE: begin
                if (resolve && mispred) begin
                    state_d       = REDIRECT;
                    redirect_pc_d = actual_next;
                end
            end
            REDIRECT: begin
                // A flush cancels the redirect even if the frontend takes it
                // in the same cycle; either way we return to IDLE.
                if (rob_flush_in || redirect_ready_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q            <= IDLE;
            complete_valid_q   <= 1'b0;
            complete_rob_idx_q <= '0;
            mispredict_q       <= 1'b0;
            flush_q            <= 1'b0;
            redirect_pc_q      <= 64'd0;
        end else begin
            state_q            <= state_d;
            complete_valid_q   <= complete_valid_d;
            complete_rob_idx_q <= complete_rob_idx_d;
            mispredict_q       <= mispredict_d;
            flush_q            <= flush_d;
            redirect_pc_q      <= redirect_pc_d;
        end
    end

`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_branches_q, perf_branches_d;
    logic [31:0] perf_mispred_q, perf_mispred_d;

    // Counters step together with the completion register, so they already
    // include a completion while its pulse is visible.
    always_comb begin
        perf_branches_d = perf_branches_q;
        perf_mispred_d  = perf_mispred_q;
        if (complete_valid_d && (perf_branches_q != 32'hFFFF_FFFF)) begin
            perf_branches_d = perf_branches_q + 32'd1;
        end
        if (mispredict_d && (perf_mispred_q != 32'hFFFF_FFFF)) begin
            perf_mispred_d = perf_mispred_q + 32'd1;
        end
    end

    // Saturating performance counter registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            perf_branches_q <= 32'd0;
            perf_mispred_q  <= 32'd0;
        end else begin
            perf_branches_q <= perf_branches_d;
            perf_mispred_q  <= perf_mispred_d;
        end
    end

    assign perf_branches_out = perf_branches_q;
    assign perf_mispred_out  = perf_mispred_q;
`else
    assign perf_branches_out = 32'd0;
    assign perf_mispred_out  = 32'd0;
`endif

endmodule

// File: tb/tb_bru_redirect_unit.sv
// Directed testbench for bru_redirect_unit; honours BRU_PERF_CNT_EN if defined.
module tb_bru_redirect_unit;

    logic        clk_in;
    logic        rst_in;
    logic        valid_in;
    logic        ready_out;
    logic [5:0]  rob_idx_in;
    logic [63:0] pc_in;
    logic        taken_in;
    logic [18:0] offset_in;
    logic        is_bl_in;
    logic        pred_taken_in;
    logic [63:0] pred_target_in;
    logic        rob_flush_in;
    logic        complete_valid_out;
    logic [5:0]  complete_rob_idx_out;
    logic        mispredict_out;
    logic        redirect_valid_out;
    logic [63:0] redirect_pc_out;
    logic        redirect_ready_in;
    logic        flush_out;
    logic [31:0] perf_branches_out;
    logic [31:0] perf_mispred_out;

    int checks = 0;
    int errors = 0;
    int cnt_br = 0;
    int cnt_mp = 0;

`ifdef BRU_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    bru_redirect_unit #(.ROB_IDX_W(6)) dut (
        .clk_in               (clk_in),
        .rst_in               (rst_in),
        .valid_in             (valid_in),
        .ready_out            (ready_out),
        .rob_idx_in           (rob_idx_in),
        .pc_in                (pc_in),
        .taken_in             (taken_in),
        .offset_in            (offset_in),
        .is_bl_in             (is_bl_in),
        .pred_taken_in        (pred_taken_in),
        .pred_target_in       (pred_target_in),
        .rob_flush_in         (rob_flush_in),
        .complete_valid_out   (complete_valid_out),
        .complete_rob_idx_out (complete_rob_idx_out),
        .mispredict_out       (mispredict_out),
        .redirect_valid_out   (redirect_valid_out),
        .redirect_pc_out      (redirect_pc_out),
        .redirect_ready_in    (redirect_ready_in),
        .flush_out            (flush_out),
        .perf_branches_out    (perf_branches_out),
        .perf_mispred_out     (perf_mispred_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Advance one cycle and land 1ns after the rising edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic [5:0] idx, input logic [63:0] pc, input logic [18:0] off,
                         input logic tk, input logic ptk, input logic [63:0] tgt);
        valid_in       = 1'b1;
        rob_idx_in     = idx;
        pc_in          = pc;
        offset_in      = off;
        taken_in       = tk;
        is_bl_in       = 1'b0;
        pred_taken_in  = ptk;
        pred_target_in = tgt;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; valid_in = 1'b0; rob_idx_in = '0; pc_in = '0; taken_in = 1'b0;
        offset_in = '0; is_bl_in = 1'b0; pred_taken_in = 1'b0; pred_target_in = '0;
        rob_flush_in = 1'b0; redirect_ready_in = 1'b0;
        #1;
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready_out); end
        checks++; if (redirect_valid_out !== 1'b0) begin errors++; $display("FAIL reset_rv got %b want 0", redirect_valid_out); end
        checks++; if (complete_valid_out !== 1'b0 || flush_out !== 1'b0 || mispredict_out !== 1'b0) begin
            errors++; $display("FAIL reset_outs got cv=%b fl=%b mp=%b want 0", complete_valid_out, flush_out, mispredict_out); end
        checks++; if (perf_branches_out !== 32'd0 || perf_mispred_out !== 32'd0) begin
            errors++; $display("FAIL reset_perf got %0d/%0d want 0/0", perf_branches_out, perf_mispred_out); end
        tick();
        rst_in = 1'b0;
        cnt_br = 0; cnt_mp = 0;
        $display("reset: done");
    endtask

    task automatic test_back_to_back();
        logic [63:0] pcs [4];
        logic [18:0] offs [4];
        logic        ptk [4];
        pcs[0] = 64'h4000; offs[0] = 19'h00020; ptk[0] = 1'b1;
        pcs[1] = 64'h4100; offs[1] = 19'h00004; ptk[1] = 1'b0;
        pcs[2] = 64'h4200; offs[2] = 19'h7FF00; ptk[2] = 1'b1;
        pcs[3] = 64'h4300; offs[3] = 19'h00004; ptk[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            // correct prediction: predicted target equals pc + sext(off)
            drive(6'd10 + 6'(i), pcs[i], offs[i], ptk[i], ptk[i], pcs[i] + {{45{offs[i][18]}}, offs[i]});
            tick();
            checks++; if (complete_valid_out !== 1'b1 || complete_rob_idx_out !== 6'd10 + 6'(i)) begin
                errors++; $display("FAIL b2b_complete%0d got v=%b idx=%0d want v=1 idx=%0d", i, complete_valid_out, complete_rob_idx_out, 10 + i); end
            checks++; if (mispredict_out !== 1'b0 || ready_out !== 1'b1 || redirect_valid_out !== 1'b0) begin
                errors++; $display("FAIL b2b_state%0d got mp=%b rdy=%b rv=%b want 0 1 0", i, mispredict_out, ready_out, redirect_valid_out); end
            cnt_br++;
            $display("b2b: branch %0d idx %0d completed", i, complete_rob_idx_out);
        end
        valid_in = 1'b0;
        tick();
        checks++; if (complete_valid_out !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", complete_valid_out); end
        checks++; if (perf_branches_out !== (PERF_ON ? 32'd4 : 32'd0) || perf_mispred_out !== 32'd0) begin
            errors++; $display("FAIL b2b_perf got %0d/%0d want %0d/0", perf_branches_out, perf_mispred_out, PERF_ON ? 4 : 0); end
    endtask

    task automatic test_correct_taken();
        drive(6'd5, 64'h1000, 19'h00040, 1'b1, 1'b1, 64'h1040);
        tick();
        checks++; if (complete_valid_out !== 1'b1 || complete_rob_idx_out !== 6'd5 || mispredict_out !== 1'b0) begin
            errors++; $display("FAIL correct_complete got v=%b idx=%0d mp=%b want 1 5 0", complete_valid_out, complete_rob_idx_out, mispredict_out); end
        checks++; if (redirect_valid_out !== 1'b0 || flush_out !== 1'b0 || ready_out !== 1'b1) begin
            errors++; $display("FAIL correct_noredir got rv=%b fl=%b rdy=%b want 0 0 1", redirect_valid_out, flush_out, ready_out); end
        valid_in = 1'b0;
        cnt_br++;
        tick();
        checks++; if (complete_valid_out !== 1'b0) begin errors++; $display("FAIL correct_pulse got %b want 0", complete_valid_out); end
        $display("correct_taken: idx 5 done");
    endtask

    task automatic test_direction_mispredict();
        redirect_ready_in = 1'b0;
        drive(6'd9, 64'h2000, 19'h00004, 1'b0, 1'b1, 64'h2100);
        tick();
        checks++; if (complete_valid_out !== 1'b1 || complete_rob_idx_out !== 6'd9 || mispredict_out !== 1'b1) begin
            errors++; $display("FAIL dir_complete got v=%b idx=%0d mp=%b want 1 9 1", complete_valid_out, complete_rob_idx_out, mispredict_out); end
        checks++; if (flush_out !== 1'b1 || redirect_valid_out !== 1'b1 || redirect_pc_out !== 64'h2004 || ready_out !== 1'b0) begin
            errors++; $display("FAIL dir_redirect got fl=%b rv=%b pc=%h rdy=%b want 1 1 2004 0", flush_out, redirect_valid_out, redirect_pc_out, ready_out); end
        cnt_br++; cnt_mp++;
        // A new branch is offered while busy; it must not be taken.
        drive(6'd20, 64'h6000, 19'h00004, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (complete_valid_out !== 1'b0 || flush_out !== 1'b0) begin
                errors++; $display("FAIL dir_hold_pulse%0d got cv=%b fl=%b want 0 0", i, complete_valid_out, flush_out); end
            checks++; if (redirect_valid_out !== 1'b1 || redirect_pc_out !== 64'h2004 || ready_out !== 1'b0) begin
                errors++; $display("FAIL dir_hold%0d got rv=%b pc=%h rdy=%b want 1 2004 0", i, redirect_valid_out, redirect_pc_out, ready_out); end
        end
        valid_in = 1'b0;
        redirect_ready_in = 1'b1;
        tick();
        checks++; if (redirect_valid_out !== 1'b0 || ready_out !== 1'b1 || complete_valid_out !== 1'b0) begin
            errors++; $display("FAIL dir_handshake got rv=%b rdy=%b cv=%b want 0 1 0", redirect_valid_out, ready_out, complete_valid_out); end
        $display("direction_mispredict: redirect 2004 accepted");
    endtask

    task automatic test_negative_offset();
        redirect_ready_in = 1'b1;
        drive(6'd11, 64'h3000, 19'h7FFF0, 1'b1, 1'b1, 64'h3010);
        tick();
        checks++; if (mispredict_out !== 1'b1 || flush_out !== 1'b1 || redirect_valid_out !== 1'b1 || redirect_pc_out !== 64'h2FF0) begin
            errors++; $display("FAIL neg_redirect got mp=%b fl=%b rv=%b pc=%h want 1 1 1 2ff0", mispredict_out, flush_out, redirect_valid_out, redirect_pc_out); end
        valid_in = 1'b0;
        cnt_br++; cnt_mp++;
        tick();
        checks++; if (redirect_valid_out !== 1'b0 || ready_out !== 1'b1 || flush_out !== 1'b0) begin
            errors++; $display("FAIL neg_return got rv=%b rdy=%b fl=%b want 0 1 0", redirect_valid_out, ready_out, flush_out); end
        redirect_ready_in = 1'b0;
        $display("negative_offset: redirect 2ff0");
    endtask

    task automatic test_flush_during_redirect();
        drive(6'd12, 64'h5000, 19'h00100, 1'b1, 1'b0, 64'h0);
        tick();
        checks++; if (redirect_valid_out !== 1'b1 || redirect_pc_out !== 64'h5100) begin
            errors++; $display("FAIL fdr_redirect got rv=%b pc=%h want 1 5100", redirect_valid_out, redirect_pc_out); end
        valid_in = 1'b0;
        cnt_br++; cnt_mp++;
        rob_flush_in = 1'b1;
        redirect_ready_in = 1'b1;
        tick();
        checks++; if (redirect_valid_out !== 1'b0 || ready_out !== 1'b1 || complete_valid_out !== 1'b0 || flush_out !== 1'b0) begin
            errors++; $display("FAIL fdr_flush got rv=%b rdy=%b cv=%b fl=%b want 0 1 0 0", redirect_valid_out, ready_out, complete_valid_out, flush_out); end
        rob_flush_in = 1'b0;
        redirect_ready_in = 1'b0;
        $display("flush_during_redirect: dropped");
    endtask

    task automatic test_flush_on_accept();
        rob_flush_in = 1'b1;
        drive(6'd13, 64'h7000, 19'h00004, 1'b0, 1'b1, 64'h7800);
        tick();
        checks++; if (complete_valid_out !== 1'b0 || flush_out !== 1'b0 || redirect_valid_out !== 1'b0 || ready_out !== 1'b1) begin
            errors++; $display("FAIL foa_discard got cv=%b fl=%b rv=%b rdy=%b want 0 0 0 1", complete_valid_out, flush_out, redirect_valid_out, ready_out); end
        valid_in = 1'b0;
        rob_flush_in = 1'b0;
        checks++; if (perf_branches_out !== (PERF_ON ? 32'(cnt_br) : 32'd0) || perf_mispred_out !== (PERF_ON ? 32'(cnt_mp) : 32'd0)) begin
            errors++; $display("FAIL perf_counts got %0d/%0d want %0d/%0d", perf_branches_out, perf_mispred_out,
                               PERF_ON ? cnt_br : 0, PERF_ON ? cnt_mp : 0); end
        $display("flush_on_accept: discarded");
    endtask

    task automatic test_reset_mid_redirect();
        redirect_ready_in = 1'b0;
        drive(6'd14, 64'h8000, 19'h00004, 1'b0, 1'b1, 64'h9000);
        tick();
        valid_in = 1'b0;
        checks++; if (redirect_valid_out !== 1'b1 || flush_out !== 1'b1) begin
            errors++; $display("FAIL rmr_pending got rv=%b fl=%b want 1 1", redirect_valid_out, flush_out); end
        #2;
        rst_in = 1'b1;
        #1;
        checks++; if (redirect_valid_out !== 1'b0 || flush_out !== 1'b0 || complete_valid_out !== 1'b0 || ready_out !== 1'b1) begin
            errors++; $display("FAIL rmr_async got rv=%b fl=%b cv=%b rdy=%b want 0 0 0 1", redirect_valid_out, flush_out, complete_valid_out, ready_out); end
        checks++; if (redirect_pc_out !== 64'd0 || perf_branches_out !== 32'd0 || perf_mispred_out !== 32'd0) begin
            errors++; $display("FAIL rmr_clear got pc=%h perf=%0d/%0d want 0 0/0", redirect_pc_out, perf_branches_out, perf_mispred_out); end
        tick();
        rst_in = 1'b0;
        tick();
        checks++; if (ready_out !== 1'b1 || redirect_valid_out !== 1'b0) begin
            errors++; $display("FAIL rmr_after got rdy=%b rv=%b want 1 0", ready_out, redirect_valid_out); end
        $display("reset_mid_redirect: cleared");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_correct_taken();
        test_direction_mispredict();
        test_negative_offset();
        test_flush_during_redirect();
        test_flush_on_accept();
        test_reset_mid_redirect();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bru_redirect_unit.md
# bru_redirect_unit

Branch resolution stage directly downstream of the branch-unit instruction decoder in the backend exec cluster. Takes the decoder's resolved outcome (taken flag, signed byte offset, BL flag) plus the frontend's prediction, computes the architectural next PC, reports completion to the ROB, and on a mispredict drives a held redirect handshake to the frontend with a one-cycle flush pulse. Single-entry, one-cycle latency, backpressured while a redirect is outstanding.

## Interface

- `ROB_IDX_W`, default 6: ROB index width.
- `clk_in`  in  1  clock; all state updates on the rising edge.
- `rst_in`  in  1  reset, asynchronous and active-high.
- `valid_in`  in  1  resolved branch present.
- `ready_out`  out  1  block can accept; equals (state == IDLE).
- `rob_idx_in`  in  ROB_IDX_W  ROB entry of the branch.
- `pc_in`  in  64  PC of the branch.
- `taken_in`  in  1  resolved direction from the decoder.
- `offset_in`  in  19  signed byte offset from the decoder; the not-taken case arrives as 4.
- `is_bl_in`  in  1  branch is BL; informational only, no special handling.
- `pred_taken_in`  in  1  frontend predicted direction.
- `pred_target_in`  in  64  frontend predicted taken target.
- `rob_flush_in`  in  1  external ROB flush (exception or older mispredict).
- `complete_valid_out`  out  1  one-cycle completion pulse to the ROB.
- `complete_rob_idx_out`  out  ROB_IDX_W  ROB index for the completion.
- `mispredict_out`  out  1  qualifies the completion; high when the prediction was wrong.
- `redirect_valid_out`  out  1  redirect request to the frontend.
- `redirect_pc_out`  out  64  correct next PC.
- `redirect_ready_in`  in  1  frontend accepts the redirect.
- `flush_out`  out  1  one-cycle pulse, backend squash of younger ops.
- `perf_branches_out`  out  32  resolved-branch count (macro-gated).
- `perf_mispred_out`  out  32  mispredict count (macro-gated).

## Operation

- Accept: a branch is captured when valid_in and ready_out are both high on a clock edge.
- Address math: actual_next = pc_in + sext64(offset_in).
  - pred_next = pred_taken_in ? pred_target_in : pc_in + 4.
  - Additions are 64-bit modular; wrap-around is ignored.
- Mispredict condition: actual_next != pred_next. Direction-only and target-only mismatches are both mispredicts.
- States:
  - IDLE to REDIRECT: on accepting a mispredicted branch, unless rob_flush_in is high in that cycle.
  - REDIRECT to IDLE: on the redirect_valid_out && redirect_ready_in handshake.
  - REDIRECT to IDLE: on rob_flush_in. The redirect is dropped; no completion is re-sent.
- Redirect hold: while in REDIRECT, redirect_valid_out is high and redirect_pc_out is held stable until the handshake.
- Correct prediction: state stays IDLE; only the completion is produced.
- rob_flush_in in IDLE, same cycle as an accept: the branch is discarded. No completion, no redirect, no flush_out.
- Handshake and rob_flush_in in the same cycle: flush wins; next state is IDLE. The frontend must tolerate the accepted redirect; the flush overrides it.
- Reset values: state IDLE, ready_out 1, every registered output 0, perf counters 0.

## Timing

- Accept at edge N:
  - complete_valid_out, complete_rob_idx_out and mispredict_out are valid during cycle N+1, for exactly one cycle.
  - For a mispredict, flush_out pulses in cycle N+1 and redirect_valid_out rises in cycle N+1.
- The earliest next accept after a mispredict is the cycle after the handshake. ready_out is 0 throughout REDIRECT.
- Back-to-back correct predictions run at one accept per cycle.
- redirect_valid_out never drops without a handshake or a flush.
- Asserting rst_in at any time immediately clears all state, including mid-REDIRECT. Outputs go to reset values without waiting for a clock edge.

## Configuration

- `BRU_PERF_CNT_EN` defined:
  - perf_branches_out increments on every completion.
  - perf_mispred_out increments on every completion with mispredict_out set.
  - Both are saturating at 32'hFFFF_FFFF and cleared by reset.
- `BRU_PERF_CNT_EN` undefined: both outputs are tied to 0 and no counter flops are built.

## Test plan

- Predicted-correct taken: pc 0x1000, offset 0x40, taken 1, pred_taken 1, pred_target 0x1040 -> next cycle complete_valid 1, mispredict 0, no redirect, ready_out stays 1.
- Direction mispredict: pc 0x2000, offset 4 (not taken), pred_taken 1, pred_target 0x2100 -> next cycle mispredict 1, flush_out pulse, redirect_pc 0x2004. With redirect_ready low for 3 cycles, valid and pc are held and ready_out is 0; the handshake returns state to IDLE.
- Negative offset target mismatch: pc 0x3000, offset 19'h7FFF0 (-16), taken 1, pred_target 0x3010 -> redirect_pc 0x2FF0.
- Flush during REDIRECT: mispredict pending, rob_flush_in high with redirect_ready_in high in the same cycle -> next cycle redirect_valid 0, ready_out 1, no second completion.
- Back-to-back: 4 correct branches on consecutive cycles -> 4 consecutive completion pulses with matching ROB indices. With BRU_PERF_CNT_EN, perf_branches_out = 4 and perf_mispred_out = 0.
- Reset mid-REDIRECT: rst_in asserted asynchronously -> redirect_valid_out, flush_out and the counters go to 0 immediately; ready_out goes to 1.
